// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave, MSB first, oversampled by clk.
// Optional rx overrun tracking (rx_ack/overrun ports) is enabled by defining SPIS_OVERRUN_EN.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_wr,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
`ifdef SPIS_OVERRUN_EN
    ,
    input  logic             rx_ack,
    output logic             overrun
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic sck_prev_q, cs_prev_q;
    logic sck_s, cs_s, mosi_s;
    logic sck_r, sck_f, cs_fall, cs_rise;

    logic [WIDTH-1:0] tx_buf_q, tx_buf_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             miso_q, miso_d, rx_valid_q, rx_valid_d, done_q, done_d;

    // cs synchronizer resets low so a frame already in flight at reset release is never joined
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign sck_r   = sck_s & ~sck_prev_q;
    assign sck_f   = ~sck_s & sck_prev_q;
    assign cs_fall = ~cs_s & cs_prev_q;
    assign cs_rise = cs_s & ~cs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_buf_d   = tx_wr ? tx_data : tx_buf_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        miso_d     = miso_q;
        rx_valid_d = 1'b0;
        done_d     = done_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    tx_sh_d   = tx_buf_q;
                    miso_d    = tx_buf_q[WIDTH-1];
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (sck_r) begin
                    rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_sh_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        done_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // The falling edge after a completed word starts the next back-to-back word
                if (sck_f) begin
                    if (done_q) begin
                        tx_sh_d = tx_buf_q;
                        miso_d  = tx_buf_q[WIDTH-1];
                        done_d  = 1'b0;
                    end else begin
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                        miso_d  = tx_sh_q[WIDTH-2];
                    end
                end
                if (cs_rise) begin
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf_q   <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_buf_q   <= tx_buf_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            miso_q     <= miso_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == SHIFT);

`ifdef SPIS_OVERRUN_EN
    logic unread_q, overrun_q;

    // An ack coinciding with a new word leaves that new word unread
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unread_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (rx_valid_q)  unread_q <= 1'b1;
            else if (rx_ack) unread_q <= 1'b0;
            if (rx_valid_q && unread_q && !rx_ack) overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave acting as SPI master.
module tb_spi_slave;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n, sck, cs, mosi, miso, tx_wr, rx_valid, busy;
    logic [7:0] tx_data, rx_data;
`ifdef SPIS_OVERRUN_EN
    logic       rx_ack, overrun;
`endif

    int nvec = 0;
    int nfail = 0;
    logic [7:0] rxq[$];

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_wr(tx_wr), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy)
`ifdef SPIS_OVERRUN_EN
        , .rx_ack(rx_ack), .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_valid === 1'b1) rxq.push_back(rx_data);

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_load(input logic [7:0] v);
        tx_data = v; tx_wr = 1'b1; tick(1); tx_wr = 1'b0;
    endtask

    task automatic cs_low();  cs = 1'b0; tick(HALF); endtask
    task automatic cs_high(); cs = 1'b1; tick(HALF); endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, input logic wr,
                        input logic [7:0] wv, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            tick(HALF);
            sck = 1'b1;
            mi[7-i] = miso;
            if (wr && i == 3) begin
                tx_data = wv; tx_wr = 1'b1; tick(1); tx_wr = 1'b0; tick(HALF-1);
            end else begin
                tick(HALF);
            end
            sck = 1'b0;
        end
    endtask

    task automatic frame1(input logic [7:0] mo, output logic [7:0] mi);
        cs_low();
        xfer(mo, 8, 1'b0, 8'h00, mi);
        cs_high();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(4);
    endtask

    vec_t       vt[5];
    logic [7:0] mi, mi2, last_rx, m_txbuf;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] got_mi[$];
    logic       bad;

    initial begin
        sck = 0; cs = 1; mosi = 0; tx_wr = 0; tx_data = 0; rst_n = 0;
`ifdef SPIS_OVERRUN_EN
        rx_ack = 0;
`endif
        tick(3);
        chk("reset_miso", miso, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1; tick(4);

        // No tx_wr since reset: slave sends zero
        rxq.delete();
        frame1(8'h96, mi);
        chk("noload_mi", mi, 8'h00);
        chk("noload_rx", rxq.size() == 1 ? rxq[0] : 8'hxx, 8'h96);

        vt[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vt[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        vt[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        vt[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81};
        vt[4] = '{8'h5A, 8'hA5, 8'hA5, 8'h5A};
        for (int k = 0; k < 5; k++) begin
            rxq.delete();
            tx_load(vt[k].tx);
            cs_low();
            chk("tbl_busy_in", busy, 1);
            xfer(vt[k].mo, 8, 1'b0, 8'h00, mi);
            cs_high();
            chk("tbl_rx_count", rxq.size(), 1);
            chk("tbl_rx", rxq.size() > 0 ? rxq[0] : 8'hxx, vt[k].exp_rx);
            chk("tbl_mi", mi, vt[k].exp_mi);
            chk("tbl_busy_out", busy, 0);
            chk("tbl_miso_idle", miso, 0);
        end

        // Back-to-back words with a mid-word tx_wr
        rxq.delete();
        tx_load(8'hA5);
        cs_low();
        xfer(8'h11, 8, 1'b1, 8'h5A, mi);
        xfer(8'h22, 8, 1'b0, 8'h00, mi2);
        cs_high();
        chk("b2b_count", rxq.size(), 2);
        chk("b2b_rx0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h11);
        chk("b2b_rx1", rxq.size() > 1 ? rxq[1] : 8'hxx, 8'h22);
        chk("b2b_mi0", mi, 8'hA5);
        chk("b2b_mi1", mi2, 8'h5A);

        // Partial frame is discarded
        rxq.delete();
        last_rx = 8'h22;
        cs_low();
        xfer(8'hE7, 3, 1'b0, 8'h00, mi);
        cs_high();
        chk("part_no_valid", rxq.size(), 0);
        chk("part_rx_hold", rx_data, last_rx);
        chk("part_miso", miso, 0);
        frame1(8'h4D, mi);
        chk("part_next_rx", rxq.size() == 1 ? rxq[0] : 8'hxx, 8'h4D);

        // tx_wr coinciding with the synchronized cs fall sends the old buffer
        tx_load(8'h66);
        rxq.delete();
        cs = 1'b0;
        tick(2);
        tx_data = 8'h99; tx_wr = 1'b1; tick(1); tx_wr = 1'b0;
        tick(HALF - 3);
        xfer(8'h01, 8, 1'b0, 8'h00, mi);
        cs_high();
        chk("txwr_csfall_old", mi, 8'h66);
        frame1(8'h02, mi);
        chk("txwr_csfall_new", mi, 8'h99);

        // sck toggling with cs high
        rxq.delete();
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sck = ~sck; mosi = i[0];
            tick(HALF);
            if (busy !== 1'b0 || miso !== 1'b0) bad = 1'b1;
        end
        sck = 1'b0; tick(HALF);
        chk("cs_high_no_valid", rxq.size(), 0);
        chk("cs_high_quiet", bad, 0);

        // Reset mid-frame at bit 4
        rxq.delete();
        tx_load(8'h3E);
        cs_low();
        xfer(8'hF0, 4, 1'b0, 8'h00, mi);
        rst_n = 1'b0; #1;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        tick(2); rst_n = 1'b1; tick(2);
        xfer(8'h0F, 8, 1'b0, 8'h00, mi);
        cs_high();
        chk("mid_rst_ignored", rxq.size(), 0);
        frame1(8'hC3, mi);
        chk("mid_rst_next_rx", rxq.size() == 1 ? rxq[0] : 8'hxx, 8'hC3);
        chk("mid_rst_next_mi", mi, 8'h00);

        // Randomized frames against a word-level model
        m_txbuf = 8'h00;
        for (int f = 0; f < 20; f++) begin
            int nw;
            logic [7:0] mo, wv;
            logic wr;
            nw = $urandom_range(1, 3);
            exp_rx.delete(); exp_tx.delete(); got_mi.delete(); rxq.delete();
            cs_low();
            for (int w = 0; w < nw; w++) begin
                mo = 8'($urandom);
                wv = 8'($urandom);
                wr = 1'($urandom);
                exp_rx.push_back(mo);
                exp_tx.push_back(m_txbuf);
                xfer(mo, 8, wr, wv, mi);
                got_mi.push_back(mi);
                if (wr) m_txbuf = wv;
            end
            if ($urandom_range(0, 3) == 0) xfer(8'($urandom), $urandom_range(1, 7), 1'b0, 8'h00, mi);
            cs_high();
            chk("rnd_count", rxq.size(), nw);
            for (int w = 0; w < nw; w++) begin
                chk("rnd_rx", w < rxq.size() ? rxq[w] : 8'hxx, exp_rx[w]);
                chk("rnd_mi", got_mi[w], exp_tx[w]);
            end
            chk("rnd_busy", busy, 0);
        end

`ifdef SPIS_OVERRUN_EN
        do_reset();
        chk("ovr_reset", overrun, 0);
        frame1(8'h12, mi);
        frame1(8'h34, mi);
        chk("ovr_set", overrun, 1);
        chk("ovr_rx_newest", rx_data, 8'h34);
        do_reset();
        frame1(8'h56, mi);
        rx_ack = 1'b1; tick(1); rx_ack = 1'b0;
        frame1(8'h78, mi);
        chk("ovr_acked", overrun, 0);
        chk("ovr_acked_rx", rx_data, 8'h78);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
